// File: rtl/ctrl_pipeline_pkg.sv
// Shared constants for the pipeline control path: specifier width, bundle bit positions,
// forwarding select codes and the decoder opcodes.
package ctrl_pipeline_pkg;

  localparam int REG_W = 5;

  localparam int EX_REGDST   = 3;
  localparam int EX_ALUOP_HI = 2;
  localparam int EX_ALUOP_LO = 1;
  localparam int EX_ALUSRC   = 0;

  localparam int M_BRANCH   = 3;
  localparam int M_MEMREAD  = 2;
  localparam int M_MEMWRITE = 1;
  localparam int M_JUMP     = 0;

  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;

  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef logic [3:0] ex_ctrl_t;
  typedef logic [3:0] m_ctrl_t;
  typedef logic [1:0] wb_ctrl_t;

endpackage

// File: rtl/ctrl_fwd_unit.sv
// ALU operand forwarding select; purely combinational, zero latency, no flow control.
// EX/MEM result is younger than MEM/WB, so it wins when both match.
module ctrl_fwd_unit #(
  parameter int REG_W = 5
) (
  input  logic             mem_regwrite_i,
  input  logic [REG_W-1:0] mem_dest_i,
  input  logic             wb_regwrite_i,
  input  logic [REG_W-1:0] wb_dest_i,
  input  logic [REG_W-1:0] ex_rs_i,
  input  logic [REG_W-1:0] ex_rt_i,
  output logic [1:0]       fwd_a_o,
  output logic [1:0]       fwd_b_o
);
  import ctrl_pipeline_pkg::*;

  function automatic logic [1:0] pick_src(input logic [REG_W-1:0] src);
    logic [1:0] sel;
    sel = FWD_REG;
    // r0 is hardwired zero, so it never sources a forward
    if (mem_regwrite_i && (mem_dest_i != '0) && (mem_dest_i == src)) begin
      sel = FWD_EXMEM;
    end else if (wb_regwrite_i && (wb_dest_i != '0) && (wb_dest_i == src)) begin
      sel = FWD_MEMWB;
    end
    return sel;
  endfunction

  assign fwd_a_o = pick_src(ex_rs_i);
  assign fwd_b_o = pick_src(ex_rt_i);

endmodule

// File: rtl/ctrl_pipeline.sv
// ID/EX, EX/MEM, MEM/WB control registers with load-use stall and flush; 1/2/3-cycle control latency.
// hold_i freezes every stage; stall_o asks the front end to hold PC and IF/ID for one cycle.
module ctrl_pipeline #(
  parameter int REG_W = ctrl_pipeline_pkg::REG_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hold_i,
  input  logic             flush_i,
  input  logic [3:0]       id_ex_i,
  input  logic [3:0]       id_m_i,
  input  logic [1:0]       id_wb_i,
  input  logic [REG_W-1:0] id_rs_i,
  input  logic [REG_W-1:0] id_rt_i,
  input  logic [REG_W-1:0] id_rd_i,
  output logic [3:0]       ex_ctrl_o,
  output logic [REG_W-1:0] ex_rs_o,
  output logic [REG_W-1:0] ex_rt_o,
  output logic [3:0]       mem_ctrl_o,
  output logic [REG_W-1:0] mem_dest_o,
  output logic [1:0]       wb_ctrl_o,
  output logic [REG_W-1:0] wb_dest_o,
  output logic             stall_o,
  output logic [1:0]       fwd_a_o,
  output logic [1:0]       fwd_b_o
);
  import ctrl_pipeline_pkg::*;

  typedef struct packed {
    ex_ctrl_t         ex;
    m_ctrl_t          m;
    wb_ctrl_t         wb;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic [REG_W-1:0] rd;
  } idex_t;

  typedef struct packed {
    m_ctrl_t          m;
    wb_ctrl_t         wb;
    logic [REG_W-1:0] dest;
  } exmem_t;

  typedef struct packed {
    wb_ctrl_t         wb;
    logic [REG_W-1:0] dest;
  } memwb_t;

  idex_t  r_idex;
  exmem_t r_exmem;
  memwb_t r_memwb;

  idex_t            w_cap;
  logic             w_stall;
  logic [REG_W-1:0] w_ex_dest;

  // Unknown decoder bits are stored as 0; a jump must never write memory or the regfile
  always_comb begin
    w_cap = '0;
    for (int i = 0; i < 4; i++) begin
      w_cap.ex[i] = (id_ex_i[i] === 1'b1);
      w_cap.m[i]  = (id_m_i[i] === 1'b1);
    end
    for (int i = 0; i < 2; i++) begin
      w_cap.wb[i] = (id_wb_i[i] === 1'b1);
    end
    for (int i = 0; i < REG_W; i++) begin
      w_cap.rs[i] = (id_rs_i[i] === 1'b1);
      w_cap.rt[i] = (id_rt_i[i] === 1'b1);
      w_cap.rd[i] = (id_rd_i[i] === 1'b1);
    end
    if (w_cap.m[M_JUMP]) begin
      w_cap.m[M_MEMREAD]    = 1'b0;
      w_cap.m[M_MEMWRITE]   = 1'b0;
      w_cap.wb[WB_REGWRITE] = 1'b0;
    end
  end

  assign w_stall = r_idex.m[M_MEMREAD] && (r_idex.rt != '0) &&
                   ((r_idex.rt == id_rs_i) || (r_idex.rt == id_rt_i)) && !flush_i;

  assign w_ex_dest = r_idex.ex[EX_REGDST] ? r_idex.rd : r_idex.rt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idex  <= '0;
      r_exmem <= '0;
      r_memwb <= '0;
    end else if (!hold_i) begin
      r_memwb.wb   <= r_exmem.wb;
      r_memwb.dest <= r_exmem.dest;
      if (flush_i) begin
        r_idex  <= '0;
        r_exmem <= '0;
      end else begin
        r_exmem.m    <= r_idex.m;
        r_exmem.wb   <= r_idex.wb;
        r_exmem.dest <= w_ex_dest;
        r_idex       <= w_stall ? idex_t'('0) : w_cap;
      end
    end
  end

  ctrl_fwd_unit #(.REG_W(REG_W)) u_fwd (
    .mem_regwrite_i (r_exmem.wb[WB_REGWRITE]),
    .mem_dest_i     (r_exmem.dest),
    .wb_regwrite_i  (r_memwb.wb[WB_REGWRITE]),
    .wb_dest_i      (r_memwb.dest),
    .ex_rs_i        (r_idex.rs),
    .ex_rt_i        (r_idex.rt),
    .fwd_a_o        (fwd_a_o),
    .fwd_b_o        (fwd_b_o)
  );

  assign ex_ctrl_o  = r_idex.ex;
  assign ex_rs_o    = r_idex.rs;
  assign ex_rt_o    = r_idex.rt;
  assign mem_ctrl_o = r_exmem.m;
  assign mem_dest_o = r_exmem.dest;
  assign wb_ctrl_o  = r_memwb.wb;
  assign wb_dest_o  = r_memwb.dest;
  assign stall_o    = w_stall;

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Bench for ctrl_pipeline: directed scenarios plus a randomized run against an
// instruction-record model of the three pipeline slots.
module tb_ctrl_pipeline;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       hold_i, flush_i;
  logic [3:0] id_ex_i, id_m_i;
  logic [1:0] id_wb_i;
  logic [4:0] id_rs_i, id_rt_i, id_rd_i;
  logic [3:0] ex_ctrl_o, mem_ctrl_o;
  logic [4:0] ex_rs_o, ex_rt_o, mem_dest_o, wb_dest_o;
  logic [1:0] wb_ctrl_o, fwd_a_o, fwd_b_o;
  logic       stall_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ctrl_pipeline #(.REG_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .hold_i(hold_i), .flush_i(flush_i),
    .id_ex_i(id_ex_i), .id_m_i(id_m_i), .id_wb_i(id_wb_i),
    .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .id_rd_i(id_rd_i),
    .ex_ctrl_o(ex_ctrl_o), .ex_rs_o(ex_rs_o), .ex_rt_o(ex_rt_o),
    .mem_ctrl_o(mem_ctrl_o), .mem_dest_o(mem_dest_o),
    .wb_ctrl_o(wb_ctrl_o), .wb_dest_o(wb_dest_o),
    .stall_o(stall_o), .fwd_a_o(fwd_a_o), .fwd_b_o(fwd_b_o)
  );

  // An instruction as it travels: its control bundles plus the register it will write
  typedef struct packed {
    logic [3:0] ex;
    logic [3:0] m;
    logic [1:0] wb;
    logic [4:0] rs, rt, rd, dest;
  } instr_t;

  localparam instr_t BUBBLE = '0;
  instr_t pipe [3];  // [0] in EX, [1] in MEM, [2] in WB

  function automatic instr_t mk_instr(input logic [3:0] ex, input logic [3:0] m,
                                      input logic [1:0] wb, input logic [4:0] rs,
                                      input logic [4:0] rt, input logic [4:0] rd);
    instr_t t;
    for (int i = 0; i < 4; i++) begin t.ex[i] = (ex[i] === 1'b1); t.m[i] = (m[i] === 1'b1); end
    for (int i = 0; i < 2; i++) t.wb[i] = (wb[i] === 1'b1);
    for (int i = 0; i < 5; i++) begin
      t.rs[i] = (rs[i] === 1'b1); t.rt[i] = (rt[i] === 1'b1); t.rd[i] = (rd[i] === 1'b1);
    end
    if (t.m[0]) begin t.m[2] = 1'b0; t.m[1] = 1'b0; t.wb[1] = 1'b0; end
    t.dest = t.ex[3] ? t.rd : t.rt;
    return t;
  endfunction

  function automatic logic model_stall();
    return pipe[0].m[2] && (pipe[0].rt != 0) && !flush_i &&
           ((pipe[0].rt == id_rs_i) || (pipe[0].rt == id_rt_i));
  endfunction

  function automatic logic [1:0] model_fwd(input logic [4:0] r);
    for (int age = 1; age <= 2; age++) begin
      if (r != 0 && pipe[age].wb[1] && pipe[age].dest == r) return (age == 1) ? 2'b10 : 2'b01;
    end
    return 2'b00;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 3; k++) pipe[k] = BUBBLE;
  endfunction

  task automatic set_in(input logic [3:0] ex, input logic [3:0] m, input logic [1:0] wb,
                        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input logic fl, input logic hd);
    id_ex_i = ex; id_m_i = m; id_wb_i = wb;
    id_rs_i = rs; id_rt_i = rt; id_rd_i = rd;
    flush_i = fl; hold_i = hd;
    #1;
  endtask

  task automatic nop();
    set_in(4'b0, 4'b0, 2'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
  endtask

  // Advance the model by one clock using the current inputs, then move to the next falling edge
  task automatic tick();
    instr_t nw;
    logic   st;
    st = model_stall();
    nw = mk_instr(id_ex_i, id_m_i, id_wb_i, id_rs_i, id_rt_i, id_rd_i);
    if (!hold_i) begin
      pipe[2] = pipe[1];
      pipe[1] = flush_i ? BUBBLE : pipe[0];
      pipe[0] = (flush_i || st) ? BUBBLE : nw;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    nop();
    checks++;
    if ({ex_ctrl_o, ex_rs_o, ex_rt_o, mem_ctrl_o, mem_dest_o, wb_ctrl_o, wb_dest_o,
         stall_o, fwd_a_o, fwd_b_o} !== '0) begin
      errors++; $display("FAIL reset_outputs: got nonzero ex=%b mem=%b wb=%b, want all 0",
                         ex_ctrl_o, mem_ctrl_o, wb_ctrl_o);
    end
    @(negedge clk); rst_n = 1'b1;
    tick();
    checks++;
    if ({ex_ctrl_o, mem_ctrl_o, wb_ctrl_o, mem_dest_o, wb_dest_o} !== '0) begin
      errors++; $display("FAIL reset_release: ex=%b mem=%b wb=%b, want 0", ex_ctrl_o, mem_ctrl_o, wb_ctrl_o);
    end
  endtask

  task automatic test_rtype();
    set_in(4'b1100, 4'b0000, 2'b10, 5'd1, 5'd2, 5'd8, 1'b0, 1'b0);
    tick(); nop();
    checks++;
    if (ex_ctrl_o !== 4'b1100) begin errors++; $display("FAIL rtype_ex: got %b want 1100", ex_ctrl_o); end
    tick();
    checks++;
    if (mem_dest_o !== 5'd8) begin errors++; $display("FAIL rtype_mem_dest: got %0d want 8", mem_dest_o); end
    tick();
    checks++;
    if (wb_ctrl_o !== 2'b10) begin errors++; $display("FAIL rtype_wb: got %b want 10", wb_ctrl_o); end
    checks++;
    if (wb_dest_o !== 5'd8) begin errors++; $display("FAIL rtype_wb_dest: got %0d want 8", wb_dest_o); end
  endtask

  task automatic test_load_use();
    set_in(4'b0001, 4'b0100, 2'b11, 5'd1, 5'd9, 5'd0, 1'b0, 1'b0);   // lw r9
    tick();
    set_in(4'b1100, 4'b0000, 2'b10, 5'd9, 5'd2, 5'd10, 1'b0, 1'b0);  // add r10,r9,r2
    checks++;
    if (stall_o !== 1'b1) begin errors++; $display("FAIL loaduse_stall: got %b want 1", stall_o); end
    tick();
    checks++;
    if (ex_ctrl_o !== 4'b0000) begin errors++; $display("FAIL loaduse_bubble: got %b want 0000", ex_ctrl_o); end
    checks++;
    if (stall_o !== 1'b0) begin errors++; $display("FAIL loaduse_stall_once: got %b want 0", stall_o); end
    tick(); nop();
    checks++;
    if (ex_ctrl_o !== 4'b1100) begin errors++; $display("FAIL loaduse_issue: got %b want 1100", ex_ctrl_o); end
    checks++;
    if (fwd_a_o !== 2'b01) begin errors++; $display("FAIL loaduse_fwd_a: got %b want 01", fwd_a_o); end
    tick();
    checks++;
    if (ex_ctrl_o !== 4'b0000 || mem_dest_o !== 5'd10) begin
      errors++; $display("FAIL loaduse_once: ex=%b dest=%0d want 0000/10", ex_ctrl_o, mem_dest_o);
    end
  endtask

  task automatic test_flush();
    set_in(4'b1100, 4'b0000, 2'b10, 5'd1, 5'd2, 5'd5, 1'b0, 1'b0);   // older add r5
    tick();
    set_in(4'b0010, 4'b1000, 2'b00, 5'd6, 5'd7, 5'd0, 1'b0, 1'b0);   // beq
    tick();
    set_in(4'b1100, 4'b0000, 2'b10, 5'd1, 5'd2, 5'd11, 1'b0, 1'b0);  // younger 1
    tick();
    set_in(4'b1100, 4'b0000, 2'b10, 5'd3, 5'd4, 5'd12, 1'b1, 1'b1);  // younger 2, held
    tick();
    checks++;
    if (ex_ctrl_o !== 4'b1100 || mem_ctrl_o !== 4'b1000) begin
      errors++; $display("FAIL flush_under_hold: ex=%b mem=%b want 1100/1000", ex_ctrl_o, mem_ctrl_o);
    end
    set_in(4'b1100, 4'b0000, 2'b10, 5'd3, 5'd4, 5'd12, 1'b1, 1'b0);
    checks++;
    if (wb_ctrl_o !== 2'b10) begin errors++; $display("FAIL flush_pre_wb: got %b want 10", wb_ctrl_o); end
    tick(); nop();
    checks++;
    if (ex_ctrl_o !== 4'b0000) begin errors++; $display("FAIL flush_ex: got %b want 0000", ex_ctrl_o); end
    checks++;
    if (mem_ctrl_o !== 4'b0000) begin errors++; $display("FAIL flush_mem: got %b want 0000", mem_ctrl_o); end
    checks++;
    if (wb_ctrl_o !== 2'b00 || wb_dest_o !== 5'd7) begin
      errors++; $display("FAIL flush_wb_advance: wb=%b dest=%0d want 00/7", wb_ctrl_o, wb_dest_o);
    end
  endtask

  task automatic test_jump_x();
    set_in(4'b0000, 4'b0xx1, 2'bxx, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    tick(); nop();
    tick();
    checks++;
    if (mem_ctrl_o !== 4'b0001) begin errors++; $display("FAIL jump_m: got %b want 0001", mem_ctrl_o); end
    tick();
    checks++;
    if (wb_ctrl_o !== 2'b00) begin errors++; $display("FAIL jump_wb: got %b want 00", wb_ctrl_o); end
    checks++;
    if ($isunknown({ex_ctrl_o, ex_rs_o, ex_rt_o, mem_ctrl_o, mem_dest_o, wb_ctrl_o, wb_dest_o,
                    stall_o, fwd_a_o, fwd_b_o}) !== 1'b0) begin
      errors++; $display("FAIL jump_no_x: got unknown outputs, want none");
    end
  endtask

  task automatic test_forward();
    set_in(4'b1100, 4'b0000, 2'b10, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0);   // add r3
    tick();
    set_in(4'b1100, 4'b0000, 2'b10, 5'd3, 5'd3, 5'd4, 1'b0, 1'b0);   // sub r4,r3,r3
    tick(); nop();
    checks++;
    if (fwd_a_o !== 2'b10 || fwd_b_o !== 2'b10) begin
      errors++; $display("FAIL fwd_exmem: a=%b b=%b want 10/10", fwd_a_o, fwd_b_o);
    end
    set_in(4'b1100, 4'b0000, 2'b10, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0);
    tick(); nop(); tick();
    set_in(4'b1100, 4'b0000, 2'b10, 5'd3, 5'd3, 5'd4, 1'b0, 1'b0);
    tick(); nop();
    checks++;
    if (fwd_a_o !== 2'b01 || fwd_b_o !== 2'b01) begin
      errors++; $display("FAIL fwd_memwb: a=%b b=%b want 01/01", fwd_a_o, fwd_b_o);
    end
    set_in(4'b1100, 4'b0000, 2'b10, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0);   // add r0
    tick();
    set_in(4'b1100, 4'b0000, 2'b10, 5'd0, 5'd0, 5'd4, 1'b0, 1'b0);
    tick(); nop();
    checks++;
    if (fwd_a_o !== 2'b00 || fwd_b_o !== 2'b00) begin
      errors++; $display("FAIL fwd_r0: a=%b b=%b want 00/00", fwd_a_o, fwd_b_o);
    end
    set_in(4'b1100, 4'b0000, 2'b10, 5'd1, 5'd2, 5'd6, 1'b0, 1'b0);
    tick();
    set_in(4'b1100, 4'b0000, 2'b10, 5'd1, 5'd2, 5'd6, 1'b0, 1'b0);
    tick();
    set_in(4'b1100, 4'b0000, 2'b10, 5'd6, 5'd1, 5'd7, 1'b0, 1'b0);
    tick(); nop();
    checks++;
    if (fwd_a_o !== 2'b10) begin errors++; $display("FAIL fwd_priority: a=%b want 10", fwd_a_o); end
  endtask

  task automatic test_reset_hold();
    for (int k = 0; k < 3; k++) begin
      set_in(4'b1100, 4'b0000, 2'b10, 5'd1, 5'd2, 5'(13 + k), 1'b0, 1'b0);
      tick();
    end
    set_in(4'b1100, 4'b0000, 2'b10, 5'd13, 5'd14, 5'd20, 1'b0, 1'b1);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({ex_ctrl_o, ex_rs_o, ex_rt_o, mem_ctrl_o, mem_dest_o, wb_ctrl_o, wb_dest_o,
         stall_o, fwd_a_o, fwd_b_o} !== '0) begin
      errors++; $display("FAIL reset_hold_now: ex=%b mem=%b wb=%b want 0", ex_ctrl_o, mem_ctrl_o, wb_ctrl_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    nop();
    tick();
    checks++;
    if ({ex_ctrl_o, mem_ctrl_o, mem_dest_o, wb_ctrl_o, wb_dest_o, fwd_a_o, fwd_b_o} !== '0) begin
      errors++; $display("FAIL reset_hold_after: ex=%b mem=%b wb=%b want 0", ex_ctrl_o, mem_ctrl_o, wb_ctrl_o);
    end
  endtask

  task automatic test_random();
    logic       keep = 1'b0;
    logic [3:0] m;
    for (int c = 0; c < 400; c++) begin
      if (!keep) begin
        m = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 3) != 0) m[0] = 1'b0;
        id_ex_i = 4'($urandom_range(0, 15)); id_m_i = m; id_wb_i = 2'($urandom_range(0, 3));
        id_rs_i = 5'($urandom_range(0, 7)); id_rt_i = 5'($urandom_range(0, 7));
        id_rd_i = 5'($urandom_range(0, 7));
      end
      flush_i = ($urandom_range(0, 7) == 0);
      hold_i  = ($urandom_range(0, 7) == 0);
      #1;
      checks++;
      if (stall_o !== model_stall()) begin errors++; $display("FAIL rnd_stall c=%0d: got %b want %b", c, stall_o, model_stall()); end
      checks++;
      if (ex_ctrl_o !== pipe[0].ex) begin errors++; $display("FAIL rnd_ex c=%0d: got %b want %b", c, ex_ctrl_o, pipe[0].ex); end
      checks++;
      if (ex_rs_o !== pipe[0].rs || ex_rt_o !== pipe[0].rt) begin
        errors++; $display("FAIL rnd_spec c=%0d: got %0d/%0d want %0d/%0d", c, ex_rs_o, ex_rt_o, pipe[0].rs, pipe[0].rt);
      end
      checks++;
      if (mem_ctrl_o !== pipe[1].m) begin errors++; $display("FAIL rnd_mem c=%0d: got %b want %b", c, mem_ctrl_o, pipe[1].m); end
      checks++;
      if (mem_dest_o !== pipe[1].dest) begin errors++; $display("FAIL rnd_mem_dest c=%0d: got %0d want %0d", c, mem_dest_o, pipe[1].dest); end
      checks++;
      if (wb_ctrl_o !== pipe[2].wb) begin errors++; $display("FAIL rnd_wb c=%0d: got %b want %b", c, wb_ctrl_o, pipe[2].wb); end
      checks++;
      if (wb_dest_o !== pipe[2].dest) begin errors++; $display("FAIL rnd_wb_dest c=%0d: got %0d want %0d", c, wb_dest_o, pipe[2].dest); end
      checks++;
      if (fwd_a_o !== model_fwd(pipe[0].rs)) begin errors++; $display("FAIL rnd_fwd_a c=%0d: got %b want %b", c, fwd_a_o, model_fwd(pipe[0].rs)); end
      checks++;
      if (fwd_b_o !== model_fwd(pipe[0].rt)) begin errors++; $display("FAIL rnd_fwd_b c=%0d: got %b want %b", c, fwd_b_o, model_fwd(pipe[0].rt)); end
      // the front end re-presents the same instruction while stalled or frozen
      keep = hold_i || model_stall();
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within 200000 time units");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_rtype();
    test_load_use();
    test_flush();
    test_jump_x();
    test_forward();
    test_reset_hold();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
